// File: rtl/cp_insert_if.sv
// Sample-stream bundle for cp_insert: IFFT packet input and CP-prefixed output.
// Carries err_cnt only when CPINS_ERR_CNT_EN is defined.
interface cp_insert_if #(
    parameter int DATA_NBIT = 15
);
    logic                 cp_type;
    logic                 fst_cp;
    logic [11:0]          fft_num;
    logic                 din_sop;
    logic                 din_valid;
    logic                 din_eop;
    logic [DATA_NBIT-1:0] din_real;
    logic [DATA_NBIT-1:0] din_imag;
    logic                 dout_h;
    logic                 dout_s;
    logic                 dout_v;
    logic [DATA_NBIT-1:0] dout_i;
    logic [DATA_NBIT-1:0] dout_q;
    logic                 ovf;
    logic                 frm_err;
`ifdef CPINS_ERR_CNT_EN
    logic [7:0]           err_cnt;
`endif

    modport master (
        output cp_type, fst_cp, fft_num, din_sop, din_valid, din_eop, din_real, din_imag,
        input  dout_h, dout_s, dout_v, dout_i, dout_q, ovf, frm_err
`ifdef CPINS_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  cp_type, fst_cp, fft_num, din_sop, din_valid, din_eop, din_real, din_imag,
        output dout_h, dout_s, dout_v, dout_i, dout_q, ovf, frm_err
`ifdef CPINS_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion: ping-pong buffers IFFT symbols and replays CP + symbol at the sample rate.
// Optional CPINS_ERR_CNT_EN adds a saturating ovf/frm_err event counter (err_cnt).
//
// state   | meaning
// WR_IDLE | waiting for din_sop into a free bank
// WR_DATA | storing samples of the current symbol
// RD_IDLE | waiting for a full bank on a strobe
// RD_CP   | replaying the symbol tail as cyclic prefix
// RD_SYM  | replaying the whole symbol
module cp_insert #(
    parameter int DATA_NBIT    = 15,
    parameter int CLK_FS_RATIO = 5
) (
    input  logic       clk,
    input  logic       reset,
    cp_insert_if.slave bus
);
    localparam int FS_W  = (CLK_FS_RATIO > 1) ? $clog2(CLK_FS_RATIO) : 1;
    localparam int RAM_W = 2 * DATA_NBIT;

    typedef enum logic {WR_IDLE, WR_DATA} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_CP, RD_SYM} rd_state_t;

    wr_state_t            wr_state_q, wr_state_d;
    rd_state_t            rd_state_q, rd_state_d;
    logic [10:0]          wr_addr_q, wr_addr_d;
    logic [10:0]          rd_addr_q, rd_addr_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [1:0]           full_q, full_d;
    logic [1:0][11:0]     bank_fft_q, bank_fft_d;
    logic [1:0][11:0]     bank_cp_q, bank_cp_d;
    logic [1:0]           bank_fst_q, bank_fst_d;
    logic [FS_W-1:0]      fs_cnt_q, fs_cnt_d;
    logic                 rd_v_q, rd_v_d, rd_h_q, rd_h_d, rd_s_q, rd_s_d;
    logic                 dout_v_q, dout_v_d, dout_h_q, dout_h_d, dout_s_q, dout_s_d;
    logic [DATA_NBIT-1:0] dout_i_q, dout_i_d, dout_q_q, dout_q_d;
    logic                 ovf_q, ovf_d, frm_err_q, frm_err_d;

    logic [RAM_W-1:0]     ram [0:4095];
    logic [RAM_W-1:0]     ram_rd_q;
    logic                 ram_we;
    logic [11:0]          ram_waddr, ram_raddr;

    logic [7:0]           cpb_in;
    logic [11:0]          cp_in;
    logic                 wr_acc, full_set, full_clr;
    logic [10:0]          wr_ptr;
    logic [11:0]          wr_fft, wr_cnt;
    logic                 strobe, rd_issue, rd_first, rd_last;
    logic [11:0]          rd_fft;
    logic [10:0]          rd_start;

    assign cpb_in = bus.cp_type ? 8'd128 : (bus.fst_cp ? 8'd40 : 8'd36);
    assign cp_in  = 12'(cpb_in) * 12'(bus.fft_num[11:9]);

    // Write side: a sop into a full bank is refused, so the rest of that packet
    // falls on WR_IDLE and is ignored until the next sop.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_bank_d  = wr_bank_q;
        bank_fft_d = bank_fft_q;
        bank_cp_d  = bank_cp_q;
        bank_fst_d = bank_fst_q;
        wr_acc     = 1'b0;
        wr_ptr     = wr_addr_q;
        wr_fft     = bank_fft_q[wr_bank_q];
        full_set   = 1'b0;
        ovf_d      = 1'b0;
        frm_err_d  = 1'b0;
        if (bus.din_valid && bus.din_sop) begin
            if (wr_state_q == WR_DATA || !full_q[wr_bank_q]) begin
                wr_acc                = 1'b1;
                wr_ptr                = '0;
                wr_fft                = bus.fft_num;
                bank_fft_d[wr_bank_q] = bus.fft_num;
                bank_cp_d[wr_bank_q]  = cp_in;
                bank_fst_d[wr_bank_q] = bus.fst_cp;
            end else begin
                ovf_d      = 1'b1;
                wr_state_d = WR_IDLE;
            end
        end else if (bus.din_valid && wr_state_q == WR_DATA) begin
            wr_acc = 1'b1;
        end
        wr_cnt = {1'b0, wr_ptr} + 12'd1;
        if (wr_acc) begin
            wr_state_d = WR_IDLE;
            if (bus.din_eop) begin
                if (wr_cnt == wr_fft) begin
                    full_set  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    frm_err_d = 1'b1;
                end
            end else if (wr_cnt == 12'd2048) begin
                frm_err_d = 1'b1;
            end else begin
                wr_state_d = WR_DATA;
                wr_addr_d  = wr_cnt[10:0];
            end
        end
        ram_we    = wr_acc;
        ram_waddr = {wr_bank_q, wr_ptr};
    end

    always_comb begin
        strobe     = (fs_cnt_q == '0);
        fs_cnt_d   = (fs_cnt_q == FS_W'(CLK_FS_RATIO - 1)) ? '0 : fs_cnt_q + FS_W'(1);
        rd_fft     = bank_fft_q[rd_bank_q];
        rd_start   = 11'(rd_fft - bank_cp_q[rd_bank_q]);
        rd_last    = ({1'b0, rd_addr_q} == rd_fft - 12'd1);
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_bank_d  = rd_bank_q;
        rd_issue   = 1'b0;
        rd_first   = 1'b0;
        full_clr   = 1'b0;
        ram_raddr  = {rd_bank_q, rd_addr_q};
        if (strobe) begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_issue   = 1'b1;
                        rd_first   = 1'b1;
                        ram_raddr  = {rd_bank_q, rd_start};
                        rd_addr_d  = rd_start + 11'd1;
                        rd_state_d = RD_CP;
                    end
                end
                RD_CP: begin
                    rd_issue = 1'b1;
                    if (rd_last) begin
                        rd_addr_d  = '0;
                        rd_state_d = RD_SYM;
                    end else begin
                        rd_addr_d = rd_addr_q + 11'd1;
                    end
                end
                RD_SYM: begin
                    rd_issue = 1'b1;
                    if (rd_last) begin
                        full_clr   = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        rd_addr_d  = '0;
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 11'd1;
                    end
                end
                default: rd_state_d = RD_IDLE;
            endcase
        end
    end

    // Set and clear always address different banks, so both apply together.
    always_comb begin
        full_d = full_q;
        if (full_set) full_d[wr_bank_q] = 1'b1;
        if (full_clr) full_d[rd_bank_q] = 1'b0;
        rd_v_d   = rd_issue;
        rd_h_d   = rd_first;
        rd_s_d   = rd_first & bank_fst_q[rd_bank_q];
        dout_v_d = rd_v_q;
        dout_h_d = rd_h_q;
        dout_s_d = rd_s_q;
        dout_i_d = rd_v_q ? ram_rd_q[RAM_W-1:DATA_NBIT] : dout_i_q;
        dout_q_d = rd_v_q ? ram_rd_q[DATA_NBIT-1:0]     : dout_q_q;
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= {bus.din_real, bus.din_imag};
        ram_rd_q <= ram[ram_raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            bank_fft_q <= '0;
            bank_cp_q  <= '0;
            bank_fst_q <= '0;
            fs_cnt_q   <= '0;
            rd_v_q     <= 1'b0;
            rd_h_q     <= 1'b0;
            rd_s_q     <= 1'b0;
            dout_v_q   <= 1'b0;
            dout_h_q   <= 1'b0;
            dout_s_q   <= 1'b0;
            dout_i_q   <= '0;
            dout_q_q   <= '0;
            ovf_q      <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            bank_fft_q <= bank_fft_d;
            bank_cp_q  <= bank_cp_d;
            bank_fst_q <= bank_fst_d;
            fs_cnt_q   <= fs_cnt_d;
            rd_v_q     <= rd_v_d;
            rd_h_q     <= rd_h_d;
            rd_s_q     <= rd_s_d;
            dout_v_q   <= dout_v_d;
            dout_h_q   <= dout_h_d;
            dout_s_q   <= dout_s_d;
            dout_i_q   <= dout_i_d;
            dout_q_q   <= dout_q_d;
            ovf_q      <= ovf_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign bus.dout_v  = dout_v_q;
    assign bus.dout_h  = dout_h_q;
    assign bus.dout_s  = dout_s_q;
    assign bus.dout_i  = dout_i_q;
    assign bus.dout_q  = dout_q_q;
    assign bus.ovf     = ovf_q;
    assign bus.frm_err = frm_err_q;

`ifdef CPINS_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((ovf_d || frm_err_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: directed packets push expected CP+symbol samples, a monitor pops on dout_v.
module tb_cp_insert;
    localparam int N = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cp_insert_if #(.DATA_NBIT(N)) bus ();
    cp_insert #(.DATA_NBIT(N), .CLK_FS_RATIO(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic         h;
        logic         s;
        logic         gap;
        logic [N-1:0] i;
        logic [N-1:0] q;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     ovf_seen = 0;
    int     frm_seen = 0;
    longint cyc      = 0;
    longint last_v   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [N-1:0] di(input int base, input int a);
        return N'(base + a);
    endfunction

    function automatic logic [N-1:0] dq(input int base, input int a);
        logic [N-1:0] v;
        v = N'(base + a);
        return v ^ 15'h5555;
    endfunction

    task automatic push_sym(input int fft, input int cp, input bit fst, input int base, input bit first_gap);
        exp_t e;
        for (int k = 0; k < cp + fft; k++) begin
            int a;
            a     = (k < cp) ? fft - cp + k : k - cp;
            e.h   = (k == 0);
            e.s   = (k == 0) && fst;
            e.gap = (k == 0) ? first_gap : 1'b1;
            e.i   = di(base, a);
            e.q   = dq(base, a);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        bus.din_eop   = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int fft, input bit cpt, input bit fst,
                            input int base, input bit eop, input bit gaps);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.din_valid = 1'b1;
            bus.din_sop   = (k == 0);
            bus.din_eop   = eop && (k == n - 1);
            bus.cp_type   = cpt;
            bus.fst_cp    = fst;
            bus.fft_num   = 12'(fft);
            bus.din_real  = di(base, k);
            bus.din_imag  = dq(base, k);
            if (gaps) idle_in();
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_dout_v"},  bus.dout_v, 0);
        chk({tag, "_dout_h"},  bus.dout_h, 0);
        chk({tag, "_dout_s"},  bus.dout_s, 0);
        chk({tag, "_dout_i"},  bus.dout_i, 0);
        chk({tag, "_dout_q"},  bus.dout_q, 0);
        chk({tag, "_ovf"},     bus.ovf, 0);
        chk({tag, "_frm_err"}, bus.frm_err, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ovf) ovf_seen++;
            if (bus.frm_err) frm_seen++;
            if (bus.dout_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dout_v", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dout_i", bus.dout_i, mon_e.i);
                    chk("dout_q", bus.dout_q, mon_e.q);
                    chk("dout_h", bus.dout_h, mon_e.h);
                    chk("dout_s", bus.dout_s, mon_e.s);
                    if (mon_e.gap) chk("dout_v_spacing", cyc - last_v, 5);
                end
                last_v = cyc;
            end else if (bus.dout_h || bus.dout_s) begin
                chk("h_s_without_v", {bus.dout_h, bus.dout_s}, 0);
            end
        end
    end

    initial begin
        int o0, f0, c;
        bus.din_valid = 1'b0;
        bus.din_sop   = 1'b0;
        bus.din_eop   = 1'b0;
        bus.cp_type   = 1'b0;
        bus.fst_cp    = 1'b0;
        bus.fft_num   = 12'd0;
        bus.din_real  = '0;
        bus.din_imag  = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;

        // 2048 normal first-of-slot: 160 CP samples 1888..2047 then 0..2047
        push_sym(2048, 160, 1'b1, 0, 1'b0);
        send_pkt(2048, 2048, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        idle_in();
        wait_drain(20000);

        push_sym(512, 128, 1'b0, 100, 1'b0);
        send_pkt(512, 512, 1'b1, 1'b0, 100, 1'b1, 1'b0);
        idle_in();
        wait_drain(6000);

        push_sym(512, 36, 1'b0, 300, 1'b0);
        send_pkt(512, 512, 1'b0, 1'b0, 300, 1'b1, 1'b1);
        idle_in();
        wait_drain(6000);

        push_sym(1536, 108, 1'b0, 7, 1'b0);
        send_pkt(1536, 1536, 1'b0, 1'b0, 7, 1'b1, 1'b0);
        idle_in();
        wait_drain(12000);

        // three back-to-back packets: third one finds both banks full
        o0 = ovf_seen;
        f0 = frm_seen;
        push_sym(2048, 160, 1'b1, 1000, 1'b0);
        push_sym(2048, 144, 1'b0, 2000, 1'b1);
        send_pkt(2048, 2048, 1'b0, 1'b1, 1000, 1'b1, 1'b0);
        send_pkt(2048, 2048, 1'b0, 1'b0, 2000, 1'b1, 1'b0);
        send_pkt(2048, 2048, 1'b0, 1'b1, 3000, 1'b1, 1'b0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("ovf_pulses_overflow", ovf_seen - o0, 1);
        chk("frm_err_pulses_overflow", frm_seen - f0, 0);
        wait_drain(30000);

        // short packet, then an overlong one without eop
        f0 = frm_seen;
        send_pkt(2047, 2048, 1'b0, 1'b0, 500, 1'b1, 1'b0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("frm_err_pulses_short", frm_seen - f0, 1);
        f0 = frm_seen;
        send_pkt(2048, 1024, 1'b0, 1'b0, 500, 1'b0, 1'b0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("frm_err_pulses_long", frm_seen - f0, 1);
        push_sym(512, 40, 1'b1, 600, 1'b0);
        send_pkt(512, 512, 1'b0, 1'b1, 600, 1'b1, 1'b0);
        idle_in();
        wait_drain(6000);

        // reset while replaying the symbol body
        push_sym(512, 36, 1'b0, 50, 1'b0);
        send_pkt(512, 512, 1'b0, 1'b0, 50, 1'b1, 1'b0);
        idle_in();
        c = 0;
        while (exp_q.size() > 400 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("reach_rd_sym_in_time", (exp_q.size() <= 400), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midsym_reset");
        exp_q.delete();
        reset = 1'b0;
        push_sym(512, 128, 1'b1, 70, 1'b0);
        send_pkt(512, 512, 1'b1, 1'b1, 70, 1'b1, 1'b0);
        idle_in();
        wait_drain(6000);

`ifdef CPINS_ERR_CNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("err_cnt_reset", bus.err_cnt, 0);
        push_sym(512, 36, 1'b0, 80, 1'b0);
        push_sym(512, 36, 1'b0, 90, 1'b1);
        send_pkt(512, 512, 1'b0, 1'b0, 80, 1'b1, 1'b0);
        send_pkt(512, 512, 1'b0, 1'b0, 90, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            send_pkt(1, 512, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        end
        idle_in();
        repeat (2) @(negedge clk);
        chk("err_cnt_saturated", bus.err_cnt, 255);
        wait_drain(8000);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cp_insert.md
CP_INSERT -- requirements
Module: cp_insert

Interface
REQ-001 Parameters SHALL be: DATA_NBIT, default 15, I/Q sample width; CLK_FS_RATIO, default 5, clocks per output sample.
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cp_type  in  1  0 normal, 1 extended; sampled at din_sop.
REQ-005 fst_cp  in  1  symbol is first of slot; sampled at din_sop.
REQ-006 fft_num  in  12  IFFT size (2048/1536/1024/512); sampled at din_sop.
REQ-007 din_sop / din_valid / din_eop  in  1 each  IFFT core output packet framing.
REQ-008 din_real / din_imag  in  DATA_NBIT  IFFT output sample.
REQ-009 dout_h  out  1  first output sample of symbol (first CP sample).
REQ-010 dout_s  out  1  latched fst_cp of the symbol, valid with dout_h.
REQ-011 dout_v  out  1  output sample strobe.
REQ-012 dout_i / dout_q  out  DATA_NBIT  output sample.
REQ-013 ovf  out  1  one-cycle pulse: symbol dropped (both banks full).
REQ-014 frm_err  out  1  one-cycle pulse: eop with sample count != fft_num.

Function
REQ-015 Storage SHALL be a 2 x 2048 x 2*DATA_NBIT simple dual-port ping-pong RAM, data {I,Q}, 1-cycle registered read.
REQ-016 Per-bank full flag; per-bank latched fft_num, cp_num, fst_cp.
REQ-017 cp_num = CPB * (fft_num>>9), CPB = 128 if cp_type, else 40 if fst_cp, else 36 (2048 -> 160/144/512).
REQ-018 Write FSM: WR_IDLE -> WR_DATA on din_sop&din_valid if bank wr_bank not full; sample written at address 0.
REQ-019 din_sop&din_valid with wr_bank full: symbol discarded until next sop, ovf pulses one cycle later.
REQ-020 WR_DATA: each din_valid writes at incrementing address; din_sop in WR_DATA restarts at address 0, same bank.
REQ-021 din_eop&din_valid with count == fft_num: set full[wr_bank], toggle wr_bank, -> WR_IDLE.
REQ-022 din_eop with count != fft_num, or count reaching 2048 without eop: discard, frm_err pulse, -> WR_IDLE, bank not marked full.
REQ-023 Sample strobe: free-running counter 0..CLK_FS_RATIO-1; strobe at count 0.
REQ-024 Read FSM: RD_IDLE -> RD_CP on strobe when full[rd_bank]; RD_CP reads addresses fft_num-cp_num .. fft_num-1, one per strobe.
REQ-025 RD_CP -> RD_SYM after last CP address; RD_SYM reads 0 .. fft_num-1.
REQ-026 After last RD_SYM address: clear full[rd_bank], toggle rd_bank, -> RD_IDLE; next symbol may start on the following strobe.
REQ-027 Latency: dout_v asserts 2 clocks after the strobe that issued the read address; exactly cp_num+fft_num dout_v per symbol.
REQ-028 dout_h and dout_s valid only with the first dout_v of a symbol; otherwise 0.
REQ-029 Simultaneous set (write side) and clear (read side) of full flags on different banks SHALL both take effect.
REQ-030 Outputs hold dout_i/dout_q between strobes; dout_v, dout_h, dout_s, ovf, frm_err are single-cycle.

Reset
REQ-031 Reset SHALL clear: both full flags, wr_bank, rd_bank, strobe counter, both FSMs to IDLE, all outputs to 0.
REQ-032 Reset mid-symbol SHALL abort write and read; RAM contents not cleared and not used afterwards.

Configuration
REQ-033 Macro CPINS_ERR_CNT_EN: when defined, adds output err_cnt (8 bits), saturating count of ovf+frm_err events, cleared by reset; when undefined, port and counter absent, behaviour otherwise identical.

Verification
REQ-034 fft_num 2048, cp_type 0, fst_cp 1, ramp data 0..2047 -> 160 samples 1888..2047 then 0..2047, dout_h/dout_s on first, dout_v every 5 clocks.
REQ-035 fft_num 512, cp_type 1 -> 128 CP samples (384..511) then 512 samples; fst_cp 0, cp_type 0 -> 36 CP samples.
REQ-036 Three back-to-back 2048 packets at 1 sample/clock -> third dropped, ovf pulse, first two output intact, gapless.
REQ-037 Packet of 2047 samples with eop -> frm_err pulse, no output; next good packet output normally.
REQ-038 Reset asserted mid-RD_SYM -> all outputs 0 next cycle; new packet after reset output from bank 0 with correct CP.
REQ-039 With CPINS_ERR_CNT_EN, 300 overflow events -> err_cnt saturates at 255.
